// File: rtl/pattern_scan_arbiter.sv
// Round-robin shared serial pattern detector: grants one lane, scans len bits,
// counts pattern matches (overlapping or not) and reports count + lane id.
// Ports: clk, rst (async low), req/bit_in per lane, pattern/len/overlap config,
//   grant (one-hot), busy, match pulse, done pulse, done_id, match_cnt.
module pattern_scan_arbiter #(
  parameter int NREQ  = 4,
  parameter int PAT_W = 4,
  parameter int LEN_W = 8,
  parameter int CNT_W = 8,
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic [NREQ-1:0]  grant,
  output logic             busy,
  output logic             match,
  output logic             done,
  output logic [ID_W-1:0]  done_id,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]   FULL = FW'(PAT_W);
  localparam logic [NREQ-1:0] ONE  = NREQ'(1);
  localparam logic [ID_W-1:0] LAST = ID_W'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  win_q;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ov_q;
  logic [PAT_W-1:0] shreg;
  logic [FW-1:0]    fill;
  logic [LEN_W-1:0] bcnt;
  logic [CNT_W-1:0] cnt;

  logic [ID_W-1:0]  win;
  logic             any;
  logic [PAT_W-1:0] sh_nx;
  logic [FW-1:0]    fill_nx;
  logic [LEN_W-1:0] bc_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             det;

  // Descending search so the lane closest after ptr is assigned last.
  always_comb begin
    win = '0;
    any = |req;
    for (int i = NREQ; i >= 1; i--) begin
      if (req[(int'(ptr) + i) % NREQ])
        win = ID_W'((int'(ptr) + i) % NREQ);
    end
  end

  always_comb begin
    sh_nx   = {shreg[PAT_W-2:0], bit_in[win_q]};
    fill_nx = (fill == FULL) ? fill : fill + 1'b1;
    det     = (sh_nx == pat_q) && (fill_nx == FULL);
    cnt_nx  = (det && (cnt != '1)) ? cnt + 1'b1 : cnt;
    bc_nx   = bcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= LAST;
      win_q     <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      ov_q      <= 1'b0;
      shreg     <= '0;
      fill      <= '0;
      bcnt      <= '0;
      cnt       <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      match     <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      match_cnt <= '0;
    end else begin
      match <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            ptr   <= win;
            win_q <= win;
            pat_q <= pattern;
            len_q <= len;
            ov_q  <= overlap;
            shreg <= '0;
            fill  <= '0;
            bcnt  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            if (len == '0) begin
              state     <= REPORT;
              done      <= 1'b1;
              done_id   <= win;
              match_cnt <= '0;
            end else begin
              state <= SCAN;
              grant <= ONE << win;
            end
          end
        end
        SCAN: begin
          shreg <= sh_nx;
          // Non-overlap restarts the fill so matched bits are not reused.
          fill  <= (det && !ov_q) ? '0 : fill_nx;
          bcnt  <= bc_nx;
          cnt   <= cnt_nx;
          match <= det;
          if (bc_nx == len_q) begin
            state     <= REPORT;
            grant     <= '0;
            done      <= 1'b1;
            done_id   <= win_q;
            match_cnt <= cnt_nx;
          end
        end
        REPORT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// Randomized self-checking bench for pattern_scan_arbiter with a
// window-based match model and a round-robin pointer model.
module tb_pattern_scan_arbiter;

  localparam int NREQ  = 4;
  localparam int PAT_W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, bit_in, pattern;
  logic [7:0] len;
  logic       overlap;
  logic [3:0] grant, s_grant;
  logic       busy, match, done;
  logic       s_busy, s_match, s_done;
  logic [1:0] done_id, s_done_id;
  logic [7:0] match_cnt;
  logic [1:0] s_cnt;

  int checks = 0;
  int failures = 0;
  int ptr_m;

  pattern_scan_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .bit_in(bit_in),
    .pattern(pattern), .len(len), .overlap(overlap),
    .grant(grant), .busy(busy), .match(match), .done(done),
    .done_id(done_id), .match_cnt(match_cnt)
  );

  pattern_scan_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req(req), .bit_in(bit_in),
    .pattern(pattern), .len(len), .overlap(overlap),
    .grant(s_grant), .busy(s_busy), .match(s_match), .done(s_done),
    .done_id(s_done_id), .match_cnt(s_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r);
    for (int i = 1; i <= NREQ; i++)
      if (r[(ptr_m + i) % NREQ]) return (ptr_m + i) % NREQ;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    ptr_m = NREQ - 1;
  endtask

  // Called on a negedge with the DUT idle; returns on a negedge, idle again.
  task automatic run_scan(input logic [3:0] rq, input logic [3:0] pat,
                          input int ln, input bit ov,
                          input logic [255:0] b, output int n);
    logic [255:0] m;
    logic [3:0]   w;
    int id, last, expc;
    n = 0;
    m = '0;
    last = -1;
    for (int k = PAT_W - 1; k < ln; k++) begin
      for (int j = 0; j < PAT_W; j++) w[PAT_W-1-j] = b[k-PAT_W+1+j];
      if (w == pat && (ov || k - last >= PAT_W)) begin
        m[k] = 1'b1;
        n++;
        last = k;
      end
    end
    expc = (n > 255) ? 255 : n;
    id = pick(rq);
    ptr_m = id;
    req = rq;
    pattern = pat;
    len = ln[7:0];
    overlap = ov;
    bit_in = 4'($urandom);
    @(negedge clk);
    req = 4'($urandom);
    pattern = 4'($urandom);
    len = 8'($urandom);
    overlap = 1'($urandom);
    if (ln == 0) begin
      check("len0_grant", grant, 0);
      check("len0_done", done, 1);
      check("len0_busy", busy, 1);
      check("len0_id", done_id, id);
      check("len0_cnt", match_cnt, 0);
      check("len0_match", match, 0);
    end else begin
      for (int k = 0; k < ln; k++) begin
        check("grant", grant, 32'(4'b0001 << id));
        bit_in = 4'($urandom);
        bit_in[id] = b[k];
        @(negedge clk);
        check("match", match, m[k]);
        check("done", done, (k == ln - 1));
      end
      check("rep_grant", grant, 0);
      check("rep_busy", busy, 1);
      check("rep_id", done_id, id);
      check("rep_cnt", match_cnt, expc);
    end
    req = '0;
    @(negedge clk);
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_match", match, 0);
  endtask

  initial begin
    logic [255:0] b;
    int n, ln;
    logic [3:0] rq;
    rst = 1'b0;
    req = '0;
    bit_in = '0;
    pattern = '0;
    len = '0;
    overlap = 1'b0;
    ptr_m = NREQ - 1;
    #12;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_match", match, 0);
    check("rst_done", done, 0);
    check("rst_id", done_id, 0);
    check("rst_cnt", match_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    b = '0;
    b[0] = 1'b1;
    b[2] = 1'b1;
    b[4] = 1'b1;
    run_scan(4'b0001, 4'b1010, 7, 1'b1, b, n);
    check("t1_cnt", match_cnt, 2);
    check("t1_id", done_id, 0);
    run_scan(4'b0001, 4'b1010, 7, 1'b0, b, n);
    check("t2_cnt", match_cnt, 1);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_scan(4'b1111, 4'($urandom), 1, 1'b1, 256'($urandom), n);
      check("rr_id", done_id, i % 4);
    end

    b = '1;
    run_scan(4'b0001, 4'b1111, 10, 1'b1, b, n);
    check("sat_cnt", s_cnt, 3);
    check("wide_cnt", match_cnt, 7);

    run_scan(4'b0100, 4'b0000, 0, 1'b1, b, n);
    check("len0_id2", done_id, 2);

    do_reset();
    req = 4'b0010;
    pattern = 4'b0101;
    len = 8'd20;
    overlap = 1'b1;
    @(negedge clk);
    check("mid_grant", grant, 4'b0010);
    req = 4'b0101;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_grant", grant, 0);
    check("abort_busy", busy, 0);
    check("abort_match", match, 0);
    check("abort_done", done, 0);
    check("abort_cnt", match_cnt, 0);
    @(negedge clk);
    check("abort_nodone", done, 0);
    rst = 1'b1;
    ptr_m = NREQ - 1;
    run_scan(4'b0101, 4'($urandom), 3, 1'b1, 256'($urandom), n);
    check("after_rst_a", done_id, 0);
    run_scan(4'b0101, 4'($urandom), 3, 1'b1, 256'($urandom), n);
    check("after_rst_b", done_id, 2);

    for (int t = 0; t < 30; t++) begin
      rq = 4'($urandom_range(1, 15));
      ln = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
      b = {8{$urandom}};
      if ($urandom_range(0, 1) == 1) b = b | {8{$urandom}};
      run_scan(rq, 4'($urandom), ln, 1'($urandom), b, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_scan_arbiter.md
Name: pattern_scan_arbiter

Overview:
- Shares one serial pattern-detector engine (Moore-style, registered match) among NREQ serial bit-stream requesters.
- Round-robin arbiter grants one requester at a time. The controller latches the scan configuration, streams `len` bits from the granted lane, and counts pattern matches in overlapping or non-overlapping mode.
- Reports the match count and requester ID with a one-cycle done pulse.
- Sits between the serial input lanes and the status/interrupt logic.

Parameters:
- NREQ, 4, number of requesters (ID width = clog2(NREQ), min 1).
- PAT_W, 4, pattern length in bits.
- LEN_W, 8, width of burst-length field.
- CNT_W, 8, width of match counter (saturating).

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-low reset.
- req, input, NREQ, level request per lane; sampled only in IDLE.
- bit_in, input, NREQ, serial data per lane; only the granted lane is used.
- pattern, input, PAT_W, target pattern; MSB is the first bit received; latched at grant.
- len, input, LEN_W, number of bits to scan; latched at grant.
- overlap, input, 1, 1 = overlapping detection, 0 = non-overlapping; latched at grant.
- grant, output, NREQ, one-hot; high exactly while state == SCAN.
- busy, output, 1, high in SCAN and REPORT.
- match, output, 1, one-cycle pulse per detection.
- done, output, 1, one-cycle pulse at end of scan.
- done_id, output, clog2(NREQ), ID of the finished requester; held until the next done.
- match_cnt, output, CNT_W, final count; held until the next done.

Behaviour:
- Reset (async, rst=0):
  - state=IDLE; grant, busy, match, done, done_id, match_cnt, shift register, fill count and bit counter all 0.
  - RR pointer = NREQ-1, so req[0] has highest priority after reset.
- FSM states: IDLE, SCAN, REPORT; default branch goes to IDLE.
- IDLE:
  - If req != 0, pick the first set bit searching from pointer+1 with wrap-around.
  - On that edge: set grant one-hot, pointer = winner, latch pattern/len/overlap, clear shift register, fill, bit counter and running count; go to SCAN.
  - Latency: req seen in cycle t means grant is high from the edge ending cycle t.
  - If the latched len == 0, go to REPORT instead; grant stays 0.
- SCAN:
  - On each edge, sample bit_in[winner] and shift it into the PAT_W shift register at the LSB.
  - fill = min(fill+1, PAT_W); bit counter increments.
  - Detection: after the shift, {shreg} == pattern and fill == PAT_W.
  - On detection: match=1 for the following cycle; running count increments and saturates at 2^CNT_W-1.
  - Overlap=1: history is kept. Overlap=0: fill is reset to 0 on that edge, so no bit of a matched pattern is reused.
  - When the bit counter reaches len on an edge, that bit is still evaluated. Go to REPORT; grant drops.
- REPORT:
  - done=1 for one cycle; done_id and match_cnt are updated on entry to REPORT and include any final-bit match.
  - Next edge goes to IDLE.
  - A match on the last bit is coincident with done.
- Requests:
  - Requester deassertion during SCAN is ignored; the scan completes.
  - New requests wait for IDLE.
  - Minimum spacing between consecutive grants is 2 idle/report cycles.
- Configuration inputs are ignored outside the grant edge.
- Reset mid-operation: aborts immediately to reset values; no done is issued for the aborted scan.
- The RR pointer advances only on grant.

Test Plan:
- req=0001, pattern=1010, overlap=1, len=7, stream 1,0,1,0,1,0,0 -> match pulses after bits 4 and 6; done with done_id=0, match_cnt=2; grant high for exactly 7 cycles.
- Same stream with overlap=0 -> one match after bit 4; match_cnt=1.
- req=1111 held, len=1 -> grants in order 0001, 0010, 0100, 1000, 0001; done_id sequence 0, 1, 2, 3, 0.
- CNT_W=2, pattern=1111, overlap=1, len=10, all-ones stream -> 7 match pulses; match_cnt saturates at 3.
- len=0, req=0100 -> grant never asserts; done one cycle after leaving IDLE; done_id=2, match_cnt=0, no match pulse.
- Assert rst=0 mid-SCAN on lane 1 with req=0101 pending -> all outputs 0 immediately, no done. After release, grant=0001 first, then 0100.
